// File: rtl/alu_seq.sv
// Sequential ALU with a valid/ready request port and a held result port.
// Latency: 1 edge for single-cycle ops, n+1 for an n-bit shift, WIDTH+1 for MUL.
// Backpressure: one op in flight; in_ready low until the result is taken with out_ready.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       flags
);

    // One extra bit so the counter can hold WIDTH as well as any shift amount.
    localparam int CW = SHW + 1;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_CMP = 4'd3;
    localparam logic [3:0] OP_ADC = 4'd4;
    localparam logic [3:0] OP_SBC = 4'd5;
    localparam logic [3:0] OP_AND = 4'd6;
    localparam logic [3:0] OP_OR  = 4'd7;
    localparam logic [3:0] OP_XOR = 4'd8;
    localparam logic [3:0] OP_SHL = 4'd9;
    localparam logic [3:0] OP_SHR = 4'd10;
    localparam logic [3:0] OP_ASR = 4'd11;
    localparam logic [3:0] OP_MUL = 4'd12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [3:0]         op_q;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] prod;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   out_q;
    logic [3:0]         flags_q;

    logic               accept;
    logic [SHW-1:0]     shamt;
    logic               is_shift;
    logic               is_mul;
    logic               go_busy;
    logic               last_step;
    logic               cin;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out       = out_q;
    assign flags     = flags_q;

    assign accept    = in_valid && in_ready;
    assign shamt     = b[SHW-1:0];
    assign is_shift  = (opcode == OP_SHL) || (opcode == OP_SHR) || (opcode == OP_ASR);
    assign is_mul    = (opcode == OP_MUL);
    assign go_busy   = is_mul || (is_shift && (shamt != '0));
    assign last_step = (cnt == CW'(1));
    assign cin       = flags_q[2];

    // Single-cycle datapath, evaluated straight from the request inputs.
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] sc_res;
    logic [WIDTH-1:0] sc_flag_src;
    logic             sc_c;
    logic             sc_v;
    logic             sc_upd;

    always_comb begin
        sum         = '0;
        sc_res      = '0;
        sc_flag_src = '0;
        sc_c        = 1'b0;
        sc_v        = 1'b0;
        sc_upd      = 1'b1;
        case (opcode)
            OP_ADD, OP_ADC: begin
                sum    = {1'b0, a} + {1'b0, b}
                       + {{WIDTH{1'b0}}, (opcode == OP_ADC) && cin};
                sc_res = sum[WIDTH-1:0];
                sc_c   = sum[WIDTH];
                sc_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            // Subtract as a + ~b + carry-in so the carry out reads as "no borrow".
            OP_SUB, OP_CMP, OP_SBC: begin
                sum    = {1'b0, a} + {1'b0, ~b}
                       + {{WIDTH{1'b0}}, (opcode == OP_SBC) ? cin : 1'b1};
                sc_res = sum[WIDTH-1:0];
                sc_c   = sum[WIDTH];
                sc_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: sc_res = a & b;
            OP_OR:  sc_res = a | b;
            OP_XOR: sc_res = a ^ b;
            OP_SHL, OP_SHR, OP_ASR: sc_res = a;
            default: sc_upd = 1'b0;
        endcase
        sc_flag_src = sc_res;
        if (opcode == OP_CMP) begin
            sc_res = '0;
        end
    end

    // One iteration of the multi-cycle ops.
    logic [WIDTH-1:0]   sh_nxt;
    logic               sh_c;
    logic [2*WIDTH-1:0] prod_nxt;
    logic [WIDTH-1:0]   bz_res;
    logic               bz_c;

    always_comb begin
        sh_nxt = acc;
        sh_c   = 1'b0;
        case (op_q)
            OP_SHL: begin
                sh_nxt = {acc[WIDTH-2:0], 1'b0};
                sh_c   = acc[WIDTH-1];
            end
            OP_SHR: begin
                sh_nxt = {1'b0, acc[WIDTH-1:1]};
                sh_c   = acc[0];
            end
            OP_ASR: begin
                sh_nxt = {acc[WIDTH-1], acc[WIDTH-1:1]};
                sh_c   = acc[0];
            end
            default: ;
        endcase
    end

    assign prod_nxt = mplier[0] ? (prod + mcand) : prod;
    assign bz_res   = (op_q == OP_MUL) ? prod_nxt[WIDTH-1:0] : sh_nxt;
    assign bz_c     = (op_q == OP_MUL) ? (|prod_nxt[2*WIDTH-1:WIDTH]) : sh_c;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = go_busy ? BUSY : DONE;
            BUSY: if (last_step) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= OP_NOP;
            acc     <= '0;
            mplier  <= '0;
            mcand   <= '0;
            prod    <= '0;
            cnt     <= '0;
            out_q   <= '0;
            flags_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q <= opcode;
                        if (go_busy) begin
                            acc    <= a;
                            mcand  <= {{WIDTH{1'b0}}, a};
                            mplier <= b;
                            prod   <= '0;
                            cnt    <= is_mul ? CW'(WIDTH) : {1'b0, shamt};
                        end else begin
                            out_q <= sc_res;
                            if (sc_upd) begin
                                flags_q <= {sc_v, sc_c, sc_flag_src[WIDTH-1], sc_flag_src == '0};
                            end
                        end
                    end
                end
                BUSY: begin
                    acc    <= sh_nxt;
                    prod   <= prod_nxt;
                    mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
                    mplier <= {1'b0, mplier[WIDTH-1:1]};
                    cnt    <= cnt - CW'(1);
                    if (last_step) begin
                        out_q   <= bz_res;
                        flags_q <= {1'b0, bz_c, bz_res[WIDTH-1], bz_res == '0};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8): arithmetic reference model plus literal expectations.
module tb_alu_seq;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       in_valid  = 1'b0;
    logic       in_ready;
    logic [3:0] opcode    = 4'd0;
    logic [7:0] a         = 8'd0;
    logic [7:0] b         = 8'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out;
    logic [3:0] flags;

    int n_vec     = 0;
    int n_bad     = 0;
    int exp_out   = 0;
    int exp_flags = 0;
    bit exp_on    = 1'b0;
    int mflags    = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .flags     (flags)
    );

    task automatic check(input string name, input int act, input int want);
        n_vec++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Reference: results from integer arithmetic on the operand values.
    function automatic void model(input int op, input int av, input int bv, input int fin,
                                  output int o, output int f, output int lat);
        int sa, sb, s, full, r, c, v, n, cin, bor;
        bit upd;
        sa  = (av > 127) ? av - 256 : av;
        sb  = (bv > 127) ? bv - 256 : bv;
        n   = bv % 8;
        cin = (fin >> 2) & 1;
        r = 0; c = 0; v = 0; upd = 1'b1; lat = 1;
        case (op)
            1, 4: begin
                full = av + bv + ((op == 4) ? cin : 0);
                s    = sa + sb + ((op == 4) ? cin : 0);
                r = full & 255; c = full >> 8; v = int'(s > 127 || s < -128);
            end
            2, 3, 5: begin
                bor  = (op == 5) ? 1 - cin : 0;
                full = av - bv - bor;
                s    = sa - sb - bor;
                r = full & 255; c = int'(full >= 0); v = int'(s > 127 || s < -128);
            end
            6: r = av & bv;
            7: r = av | bv;
            8: r = av ^ bv;
            9: begin
                r = (av << n) & 255; c = (n > 0) ? (av >> (8 - n)) & 1 : 0; lat = n + 1;
            end
            10: begin
                r = av >> n; c = (n > 0) ? (av >> (n - 1)) & 1 : 0; lat = n + 1;
            end
            11: begin
                r = (sa >>> n) & 255; c = (n > 0) ? (sa >>> (n - 1)) & 1 : 0; lat = n + 1;
            end
            12: begin
                full = av * bv; r = full & 255; c = int'((full >> 8) != 0); lat = 9;
            end
            default: upd = 1'b0;
        endcase
        o = (op == 3 || !upd) ? 0 : r;
        f = upd ? (v * 8 + c * 4 + int'(r > 127) * 2 + int'(r == 0)) : fin;
    endfunction

    // Whenever a result is presented it must match the current expectation.
    always @(negedge clk) begin
        if (exp_on && rst_n && out_valid) begin
            check("out_while_valid", int'(out), exp_out);
            check("flags_while_valid", int'(flags), exp_flags);
        end
    end

    task automatic issue(input int op, input int av, input int bv,
                         input int lit_out, input int lit_flags, input int hold);
        int mo, mf, ml, lat;
        model(op, av, bv, mflags, mo, mf, ml);
        check("model_vs_literal_out", mo, lit_out);
        check("model_vs_literal_flags", mf, lit_flags);
        exp_out   = mo;
        exp_flags = mf;
        exp_on    = 1'b1;
        @(negedge clk);
        check("in_ready_before_accept", int'(in_ready), 1);
        opcode   = 4'(op);
        a        = 8'(av);
        b        = 8'(bv);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            check("in_ready_low_while_busy", int'(in_ready), 0);
            @(posedge clk);
            #1 lat++;
        end
        check("latency", lat, ml);
        check("out_literal", int'(out), lit_out);
        check("flags_literal", int'(flags), lit_flags);
        mflags = mf;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            opcode   = 4'($urandom_range(1, 12));
            a        = 8'($urandom);
            b        = 8'($urandom);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        in_valid = 1'b0;
        check("out_valid_drops", int'(out_valid), 0);
        check("idle_after_take", int'(in_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_out", int'(out), 0);
        check("reset_flags", int'(flags), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        issue(1,  'h7F, 'h01, 'h80, 'hA, 0);
        issue(2,  'h05, 'h05, 'h00, 'h5, 0);
        issue(2,  'h03, 'h05, 'hFE, 'h2, 0);
        issue(9,  'hC1, 'h02, 'h04, 'h4, 5);
        issue(9,  'hC1, 'h00, 'hC1, 'h2, 0);
        issue(12, 'h10, 'h11, 'h10, 'h4, 0);
        issue(4,  'h01, 'h01, 'h03, 'h0, 0);
        issue(5,  'h10, 'h01, 'h0E, 'h4, 0);
        issue(3,  'h80, 'h01, 'h00, 'hC, 0);
        issue(6,  'hF0, 'h0F, 'h00, 'h1, 0);
        issue(0,  'h12, 'h34, 'h00, 'h1, 0);
        issue(7,  'hA0, 'h05, 'hA5, 'h2, 0);
        issue(8,  'h5A, 'h5A, 'h00, 'h1, 0);
        issue(10, 'h81, 'h01, 'h40, 'h4, 0);
        issue(11, 'h81, 'h0A, 'hE0, 'h2, 0);
        issue(14, 'hFF, 'hFF, 'h00, 'h2, 0);
        issue(12, 'hFF, 'hFF, 'h01, 'h4, 2);
        issue(5,  'h00, 'h01, 'hFF, 'h2, 0);
        issue(1,  'h80, 'h80, 'h00, 'hD, 0);

        // Abort a multiply part-way with the carry flag set.
        exp_on = 1'b0;
        @(negedge clk);
        opcode   = 4'd12;
        a        = 8'h10;
        b        = 8'h11;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("mul_busy_before_reset", int'(in_ready), 0);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_in_ready", int'(in_ready), 1);
        check("abort_flags", int'(flags), 0);
        check("abort_out", int'(out), 0);
        @(negedge clk);
        rst_n  = 1'b1;
        mflags = 0;
        issue(4, 'h10, 'h20, 'h30, 'h0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
